// File: rtl/lpc_tpm_periph.sv
// LPC TPM-locality peripheral: decodes host frames on LAD/LFRAME#, issues one
// single-byte register access per frame and answers with SYNC and read data.
module lpc_tpm_periph #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lframe_n_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe,
  output logic [15:0] addr_o,
  inout  wire  [7:0]  data_io,
  output logic        data_wr_o,
  input  logic        wr_done_i,
  output logic        data_req_o,
  input  logic        data_rd_i
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [3:0] START_TPM = 4'b0101;
  localparam logic [3:0] CYC_RD    = 4'b0000;
  localparam logic [3:0] CYC_WR    = 4'b0010;
  localparam logic [3:0] SYNC_RDY  = 4'b0000;
  localparam logic [3:0] SYNC_WAIT = 4'b0110;
  localparam logic [3:0] SYNC_ERR  = 4'b1010;

  typedef enum logic [3:0] {
    IDLE, CYCTYPE, ADDR0, ADDR1, ADDR2, ADDR3, WDATA0, WDATA1,
    HTAR0, HTAR1, SYNC, RDATA0, RDATA1, PTAR0, PTAR1
  } state_t;

  state_t         state;
  logic           is_wr, pend;
  logic [WCW-1:0] wait_cnt;
  logic [7:0]     wdata, rdata;
  logic           ack, busy, timeout, do_sync;
  logic [3:0]     sync_nib;

  assign ack      = is_wr ? wr_done_i : data_rd_i;
  assign busy     = wr_done_i | data_rd_i;
  assign timeout  = (wait_cnt == WCW'(MAX_WAIT));
  assign sync_nib = ack ? SYNC_RDY : (timeout ? SYNC_ERR : SYNC_WAIT);
  // lad_o still holds the SYNC code of the cycle in progress
  assign do_sync  = (state == HTAR1 && !pend) || (state == SYNC && lad_o == SYNC_WAIT);
  assign data_io  = data_wr_o ? wdata : 8'hzz;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      lad_o      <= 4'hF;
      lad_oe     <= 1'b0;
      addr_o     <= '0;
      data_wr_o  <= 1'b0;
      data_req_o <= 1'b0;
      is_wr      <= 1'b0;
      pend       <= 1'b0;
      wait_cnt   <= '0;
      wdata      <= '0;
      rdata      <= '0;
    end else if (!lframe_n_i) begin
      // LFRAME# low aborts whatever is running and doubles as START detection
      state      <= (lad_i == START_TPM) ? CYCTYPE : IDLE;
      lad_o      <= 4'hF;
      lad_oe     <= 1'b0;
      data_wr_o  <= 1'b0;
      data_req_o <= 1'b0;
      pend       <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE:    state <= IDLE;
        CYCTYPE: begin
          is_wr    <= (lad_i == CYC_WR);
          wait_cnt <= '0;
          state    <= (lad_i == CYC_RD || lad_i == CYC_WR) ? ADDR0 : IDLE;
        end
        ADDR0: begin addr_o[15:12] <= lad_i; state <= ADDR1; end
        ADDR1: begin addr_o[11:8]  <= lad_i; state <= ADDR2; end
        ADDR2: begin addr_o[7:4]   <= lad_i; state <= ADDR3; end
        ADDR3: begin
          addr_o[3:0] <= lad_i;
          if (is_wr) state <= WDATA0;
          else begin
            state <= HTAR0;
            if (busy) pend <= 1'b1;
            else      data_req_o <= 1'b1;
          end
        end
        WDATA0: begin wdata[3:0] <= lad_i; state <= WDATA1; end
        WDATA1: begin
          wdata[7:4] <= lad_i;
          state      <= HTAR0;
          if (busy) pend <= 1'b1;
          else      data_wr_o <= 1'b1;
        end
        HTAR0: begin
          state <= HTAR1;
          if (pend && !busy) begin
            data_wr_o <= is_wr; data_req_o <= !is_wr; pend <= 1'b0;
          end
        end
        // a deferred request is raised here; SYNC waits until it is out
        HTAR1: if (pend && !busy) begin
          data_wr_o <= is_wr; data_req_o <= !is_wr; pend <= 1'b0;
        end
        SYNC: if (lad_o == SYNC_RDY && !is_wr) begin
          state <= RDATA0; lad_o <= rdata[3:0];
        end else if (lad_o != SYNC_WAIT) begin
          state <= PTAR0; lad_o <= 4'hF;
        end
        RDATA0: begin lad_o <= rdata[7:4]; state <= RDATA1; end
        RDATA1: begin lad_o <= 4'hF;       state <= PTAR0;  end
        PTAR0:  begin lad_oe <= 1'b0;      state <= PTAR1;  end
        PTAR1:  state <= IDLE;
        default: state <= IDLE;
      endcase
      if (do_sync) begin
        state  <= SYNC;
        lad_oe <= 1'b1;
        lad_o  <= sync_nib;
        if (ack || timeout) begin
          data_wr_o  <= 1'b0;
          data_req_o <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
        if (ack && !is_wr) rdata <= data_io;
      end
    end
  end
endmodule

// File: tb/tb_lpc_tpm_periph.sv
// Bench for lpc_tpm_periph: a host driving LPC frames, a register-block stub
// with programmable ack delay, and a frame-level model of the expected LAD/handshake.
module tb_lpc_tpm_periph;
  localparam int MAXW = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        lframe_n_i = 1'b1;
  logic [3:0]  lad_i = 4'hF;
  logic [3:0]  lad_o;
  logic        lad_oe;
  logic [15:0] addr_o;
  wire  [7:0]  data_io;
  logic        data_wr_o, data_req_o;
  logic        wr_done_i, data_rd_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] g;

  lpc_tpm_periph #(.MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .lframe_n_i(lframe_n_i), .lad_i(lad_i),
    .lad_o(lad_o), .lad_oe(lad_oe), .addr_o(addr_o), .data_io(data_io),
    .data_wr_o(data_wr_o), .wr_done_i(wr_done_i), .data_req_o(data_req_o),
    .data_rd_i(data_rd_i)
  );

  always #5 clk_i = ~clk_i;

  // register contents: low address byte decoded, reg 0 behaves like TPM_ACCESS
  function automatic logic [7:0] dflt(input logic [7:0] a);
    return (a == 8'h00) ? 8'h81 : (a ^ 8'h3C);
  endfunction
  function automatic logic [7:0] reg_write(input logic [7:0] cur, input logic [7:0] a,
                                           input logic [7:0] wd);
    if (a == 8'h00) return wd[1] ? (cur | 8'h20) : cur;
    return wd;
  endfunction

  // register-block stub: acks stub_dly edges after first seeing a request
  logic [7:0]   smem [256];
  logic [255:0] sval;
  logic [7:0]   stub_q;
  int           stub_cnt;
  int           stub_dly = 0;
  assign data_io = data_rd_i ? stub_q : 8'hzz;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_rd_i <= 1'b0; wr_done_i <= 1'b0; stub_cnt <= 0; sval <= '0;
    end else if (!(data_req_o || data_wr_o)) begin
      data_rd_i <= 1'b0; wr_done_i <= 1'b0; stub_cnt <= 0;
    end else if (!(data_rd_i || wr_done_i)) begin
      if (stub_cnt >= stub_dly) begin
        if (data_req_o) begin
          data_rd_i <= 1'b1;
          stub_q    <= sval[addr_o[7:0]] ? smem[addr_o[7:0]] : dflt(addr_o[7:0]);
        end else begin
          wr_done_i <= 1'b1;
          smem[addr_o[7:0]] <= reg_write(sval[addr_o[7:0]] ? smem[addr_o[7:0]] : dflt(addr_o[7:0]),
                                         addr_o[7:0], data_io);
          sval[addr_o[7:0]] <= 1'b1;
        end
      end else stub_cnt <= stub_cnt + 1;
    end
  end

  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // One host frame; d = ack delay (> MAXW means the block never answers in time).
  task automatic run_frame(input string nm, input logic [3:0] st, input logic [3:0] cyc,
                           input logic [15:0] a, input logic [7:0] wd, input int d,
                           input int abort_at, output logic [7:0] got);
    logic       lf [$];
    logic [3:0] ld [$];
    logic [3:0] exp_q [$];
    logic       valid, wr, ok;
    logic [7:0] rv;
    int         k, w, n;
    valid = (st == 4'b0101) && (cyc == 4'b0000 || cyc == 4'b0010);
    wr    = (cyc == 4'b0010);
    ok    = (d <= MAXW);
    w     = ok ? d : MAXW;
    rv    = ref_rd(a[7:0]);
    lf.push_back(1'b0); ld.push_back(st);
    lf.push_back(1'b1); ld.push_back(cyc);
    for (int i = 3; i >= 0; i--) begin lf.push_back(1'b1); ld.push_back(a[i*4 +: 4]); end
    if (wr) begin
      lf.push_back(1'b1); ld.push_back(wd[3:0]);
      lf.push_back(1'b1); ld.push_back(wd[7:4]);
    end
    k = lf.size();
    n = k + 16;
    while (lf.size() < n) begin lf.push_back(1'b1); ld.push_back(4'hF); end
    if (abort_at >= 0) begin lf[abort_at] = 1'b0; ld[abort_at] = 4'hF; end
    // SYNC starts two cycles after the request goes out (host TAR)
    for (int i = 0; i < w; i++) exp_q.push_back(4'b0110);
    exp_q.push_back(ok ? 4'b0000 : 4'b1010);
    if (ok && !wr) begin exp_q.push_back(rv[3:0]); exp_q.push_back(rv[7:4]); end
    exp_q.push_back(4'hF);
    stub_dly = d;
    got = '0;
    for (int j = 0; j < n; j++) begin
      logic e_oe, e_rq, e_wq, live;
      logic [3:0] e_nib;
      live  = valid && (abort_at < 0 || j <= abort_at);
      e_oe  = live && j >= k + 2 && j < k + 2 + exp_q.size();
      e_nib = e_oe ? exp_q[j - k - 2] : 4'hF;
      e_rq  = live && !wr && j >= k && j <= k + 1 + w;
      e_wq  = live &&  wr && j >= k && j <= k + 1 + w;
      @(negedge clk_i);
      checks++;
      if (lad_oe !== e_oe) begin
        errors++; $display("FAIL %s lad_oe cyc %0d got %b exp %b", nm, j, lad_oe, e_oe);
      end
      if (e_oe) begin
        checks++;
        if (lad_o !== e_nib) begin
          errors++; $display("FAIL %s lad_o cyc %0d got %h exp %h", nm, j, lad_o, e_nib);
        end
      end
      checks++;
      if (data_req_o !== e_rq) begin
        errors++; $display("FAIL %s data_req_o cyc %0d got %b exp %b", nm, j, data_req_o, e_rq);
      end
      checks++;
      if (data_wr_o !== e_wq) begin
        errors++; $display("FAIL %s data_wr_o cyc %0d got %b exp %b", nm, j, data_wr_o, e_wq);
      end
      if (data_wr_o === 1'b1) begin
        checks++;
        if (data_io !== wd) begin
          errors++; $display("FAIL %s data_io cyc %0d got %h exp %h", nm, j, data_io, wd);
        end
      end
      if (j == k + 3 + w) got[3:0] = lad_o;
      if (j == k + 4 + w) got[7:4] = lad_o;
      lframe_n_i = lf[j];
      lad_i      = ld[j];
    end
    if (valid && abort_at < 0) begin
      checks++;
      if (addr_o !== a) begin
        errors++; $display("FAIL %s addr_o got %h exp %h", nm, addr_o, a);
      end
      if (wr && ok) ref_mem[int'(a[7:0])] = reg_write(rv, a[7:0], wd);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if (lad_oe !== 1'b0 || lad_o !== 4'hF || addr_o !== 16'h0 ||
        data_wr_o !== 1'b0 || data_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got oe=%b lad=%h addr=%h wr=%b req=%b exp 0 F 0000 0 0",
               nm, lad_oe, lad_o, addr_o, data_wr_o, data_req_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_vals("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_read_basic();
    run_frame("read0", 4'b0101, 4'b0000, 16'h0000, 8'h00, 0, -1, g);
    checks++;
    if (g !== 8'h81) begin errors++; $display("FAIL read0 data got %h exp 81", g); end
  endtask

  task automatic test_write_read();
    run_frame("wr0", 4'b0101, 4'b0010, 16'h0000, 8'h02, 0, -1, g);
    run_frame("rd0", 4'b0101, 4'b0000, 16'h0000, 8'h00, 0, -1, g);
    checks++;
    if (g !== 8'hA1) begin errors++; $display("FAIL wr_rd data got %h exp a1", g); end
  endtask

  task automatic test_timeout();
    run_frame("rd_timeout", 4'b0101, 4'b0000, 16'h1234, 8'h00, 50, -1, g);
    run_frame("wr_timeout", 4'b0101, 4'b0010, 16'h0042, 8'h5A, 50, -1, g);
    run_frame("rd_after_to", 4'b0101, 4'b0000, 16'h0042, 8'h00, 1, -1, g);
  endtask

  task automatic test_wait_states();
    run_frame("wr_wait3", 4'b0101, 4'b0010, 16'h0077, 8'hC3, 3, -1, g);
    run_frame("rd_wait4", 4'b0101, 4'b0000, 16'h0077, 8'h00, MAXW, -1, g);
    checks++;
    if (g !== 8'hC3) begin errors++; $display("FAIL wait_rd data got %h exp c3", g); end
  endtask

  task automatic test_abort();
    run_frame("abort_addr2", 4'b0101, 4'b0000, 16'h0F00, 8'h00, 0, 4, g);
    run_frame("rd_0f00", 4'b0101, 4'b0000, 16'h0F00, 8'h00, 0, -1, g);
    run_frame("abort_sync", 4'b0101, 4'b0000, 16'h0033, 8'h00, 50, 9, g);
    run_frame("abort_wr", 4'b0101, 4'b0010, 16'h0033, 8'hEE, 50, 10, g);
    run_frame("rd_0033", 4'b0101, 4'b0000, 16'h0033, 8'h00, 2, -1, g);
  endtask

  task automatic test_bad_start();
    run_frame("start_0000", 4'b0000, 4'b0000, 16'h0000, 8'h00, 0, -1, g);
    run_frame("start_0000_w", 4'b0000, 4'b0010, 16'h0011, 8'h99, 0, -1, g);
    run_frame("bad_cyctype", 4'b0101, 4'b0100, 16'h0011, 8'h00, 0, -1, g);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      logic [7:0]  wd;
      int r, d;
      a  = 16'($urandom);
      wd = 8'($urandom);
      r  = $urandom_range(0, MAXW + 1);
      d  = (r > MAXW) ? 50 : r;
      if ($urandom_range(0, 1) == 1)
        run_frame("rand_wr", 4'b0101, 4'b0010, a, wd, d, -1, g);
      else
        run_frame("rand_rd", 4'b0101, 4'b0000, a, 8'h00, d, -1, g);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  wd;
    a  = {8'($urandom), 8'h5D};
    wd = 8'($urandom);
    run_frame("b2b_wr", 4'b0101, 4'b0010, a, wd, 0, -1, g);
    run_frame("b2b_rd", 4'b0101, 4'b0000, a, 8'h00, 0, -1, g);
    checks++;
    if (g !== wd) begin errors++; $display("FAIL b2b data got %h exp %h", g, wd); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [10];
    seq = '{4'b0101, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF};
    stub_dly = 50;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk_i);
      lframe_n_i = (j == 0) ? 1'b0 : 1'b1;
      lad_i      = seq[j];
    end
    @(negedge clk_i);
    checks++;
    if (lad_oe !== 1'b1 || data_req_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre got oe=%b req=%b exp 1 1", lad_oe, data_req_o);
    end
    #2 rst_n_i = 1'b0;
    #1 check_reset_vals("reset_mid");
    ref_mem.delete();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    run_frame("rd_after_rst", 4'b0101, 4'b0000, 16'h0000, 8'h00, 0, -1, g);
    checks++;
    if (g !== 8'h81) begin errors++; $display("FAIL after_rst data got %h exp 81", g); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_timeout();
    test_wait_states();
    test_abort();
    test_bad_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
